// File: rtl/apb_mem_arbiter.sv
// Round-robin two-requester APB3/APB4 master; REQ->ACK in 3 cycles plus one per PREADY-low cycle.
// Requesters hold REQ until ACK; optional stall watchdog is built when APB_ARB_TIMEOUT_EN is defined.
module apb_mem_arbiter #(
  parameter int ADDRWIDTH = 32,
  parameter int P_TIMEOUT = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 REQ0,
  input  logic [ADDRWIDTH-1:0] ADDR0,
  input  logic                 WRITE0,
  input  logic [31:0]          WDATA0,
  input  logic [3:0]           STRB0,
  output logic                 ACK0,
  output logic [31:0]          RDATA0,
  output logic                 ERR0,
  input  logic                 REQ1,
  input  logic [ADDRWIDTH-1:0] ADDR1,
  input  logic                 WRITE1,
  input  logic [31:0]          WDATA1,
  input  logic [3:0]           STRB1,
  output logic                 ACK1,
  output logic [31:0]          RDATA1,
  output logic                 ERR1,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  input  logic                 PREADY,
  input  logic                 PSLVERR,
  input  logic [31:0]          PRDATA
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   gnt_q, gnt_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
  logic [31:0]            pwdata_q, pwdata_d;
  logic [3:0]             pstrb_q, pstrb_d;
  logic                   ack0_q, ack0_d, ack1_q, ack1_d;
  logic                   err0_q, err0_d, err1_q, err1_d;
  logic [31:0]            rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                   elig0, elig1, pick;
  logic                   fin, fin_err;
  logic [31:0]            fin_rdata;

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0]             cnt_q, cnt_d;
`else
  logic                   unused_timeout;
  assign unused_timeout = (P_TIMEOUT == 0);
`endif

  // A requester's REQ is still high during its own ACK cycle; mask it so it is not re-granted.
  assign elig0 = REQ0 & ~ack0_q;
  assign elig1 = REQ1 & ~ack1_q;
  assign pick  = (elig0 & elig1) ? ~last_q : elig1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = 32'd0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          gnt_d    = pick;
          psel_d   = 1'b1;
          paddr_d  = pick ? ADDR1 : ADDR0;
          pwrite_d = pick ? WRITE1 : WRITE0;
          pwdata_d = pick ? WDATA1 : WDATA0;
          pstrb_d  = (pick ? WRITE1 : WRITE0) ? (pick ? STRB1 : STRB0) : 4'h0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = 8'd0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          fin       = 1'b1;
          fin_err   = PSLVERR;
          fin_rdata = PRDATA;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // Abort reads return zero data and always flag an error.
        else if (cnt_q == 8'(P_TIMEOUT)) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_rdata = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      state_d   = IDLE;
      last_d    = gnt_q;
      if (gnt_q) begin
        ack1_d = 1'b1;
        err1_d = fin_err;
        if (!pwrite_q) rdata1_d = fin_rdata;
      end else begin
        ack0_d = 1'b1;
        err0_d = fin_err;
        if (!pwrite_q) rdata0_d = fin_rdata;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= 32'd0;
      pstrb_q   <= 4'h0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end
`endif

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
  assign PPROT   = 3'b000;
  assign ACK0    = ack0_q;
  assign ACK1    = ack1_q;
  assign ERR0    = err0_q;
  assign ERR1    = err1_q;
  assign RDATA0  = rdata0_q;
  assign RDATA1  = rdata1_q;

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Directed bench for apb_mem_arbiter with a small APB memory slave; timeout case runs when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_mem_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        REQ0, REQ1, WRITE0, WRITE1;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
  logic [3:0]  STRB0, STRB1;
  logic        ACK0, ACK1, ERR0, ERR1;
  logic [31:0] RDATA0, RDATA1;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] mem [16];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        stuck_low = 1'b0;
  logic        slverr_cfg = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_mem_arbiter #(.ADDRWIDTH(32), .P_TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .REQ0(REQ0), .ADDR0(ADDR0), .WRITE0(WRITE0), .WDATA0(WDATA0), .STRB0(STRB0),
    .ACK0(ACK0), .RDATA0(RDATA0), .ERR0(ERR0),
    .REQ1(REQ1), .ADDR1(ADDR1), .WRITE1(WRITE1), .WDATA1(WDATA1), .STRB1(STRB1),
    .ACK1(ACK1), .RDATA1(RDATA1), .ERR1(ERR1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  // Slave: PREADY rises after wait_cfg low ACCESS cycles unless stuck low.
  assign PREADY  = !stuck_low && (wcnt >= wait_cfg);
  assign PSLVERR = slverr_cfg;
  assign PRDATA  = mem[PADDR[5:2]];

  always @(posedge PCLK) begin
    if (PSEL && !PENABLE) wcnt <= 0;
    else if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    if (PSEL && PENABLE && PREADY && PWRITE)
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transfer from requester idx; checks latency, APB stability while waiting, and the response pulse.
  task automatic do_req(input int idx, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int          lat;
    logic        a;
    logic        e;
    logic [31:0] rd;
    lat = 0;
    e   = 1'b0;
    rd  = 32'd0;
    @(negedge PCLK);
    if (idx == 0) begin
      ADDR0 = addr; WRITE0 = wr; WDATA0 = wd; STRB0 = st; REQ0 = 1'b1;
    end else begin
      ADDR1 = addr; WRITE1 = wr; WDATA1 = wd; STRB1 = st; REQ1 = 1'b1;
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge PCLK);
      a = (idx == 0) ? ACK0 : ACK1;
      if (a) begin
        lat = k;
        e   = (idx == 0) ? ERR0 : ERR1;
        rd  = (idx == 0) ? RDATA0 : RDATA1;
        chk({tag, "_psel_done"}, {31'd0, PSEL}, 32'd0);
        chk({tag, "_penable_done"}, {31'd0, PENABLE}, 32'd0);
        break;
      end
      chk({tag, "_psel"}, {31'd0, PSEL}, 32'd1);
      chk({tag, "_paddr"}, PADDR, addr);
      chk({tag, "_pwrite"}, {31'd0, PWRITE}, {31'd0, wr});
      chk({tag, "_pstrb"}, {28'd0, PSTRB}, wr ? {28'd0, st} : 32'd0);
      if (k >= 2) chk({tag, "_penable"}, {31'd0, PENABLE}, 32'd1);
    end
    if (idx == 0) REQ0 = 1'b0;
    else          REQ1 = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    if (!wr) chk({tag, "_rdata"}, rd, exp_rd);
    @(negedge PCLK);
    chk({tag, "_ack_pulse"}, {30'd0, ACK1, ACK0}, 32'd0);
    chk({tag, "_err_pulse"}, {30'd0, ERR1, ERR0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          n_ack;
    int          ack_cyc [4];
    int          ack_who [4];
    int          seen0, seen1;
    logic        ack_seen;

    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + i;
    PRESETn = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0; WRITE0 = 1'b0; WRITE1 = 1'b0;
    ADDR0 = 32'd0; ADDR1 = 32'd0; WDATA0 = 32'd0; WDATA1 = 32'd0;
    STRB0 = 4'h0; STRB1 = 4'h0;
    repeat (2) @(negedge PCLK);

    chk("rst_apb_ctl", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pstrb_pprot", {25'd0, PPROT, PSTRB}, 32'd0);
    chk("rst_ack_err", {28'd0, ACK1, ACK0, ERR1, ERR0}, 32'd0);
    chk("rst_rdata0", RDATA0, 32'd0);
    chk("rst_rdata1", RDATA1, 32'd0);

    // Tie from reset: expect 0,1,0,1 with ACKs at cycles 3,6,9,12.
    PRESETn = 1'b1;
    ADDR0 = 32'h20; ADDR1 = 32'h24; REQ0 = 1'b1; REQ1 = 1'b1;
    n_ack = 0; seen0 = 0; seen1 = 0;
    for (int k = 1; k <= 30 && n_ack < 4; k++) begin
      @(negedge PCLK);
      if (ACK0 && ACK1) chk("tie_both_ack", 32'd1, 32'd0);
      else if (ACK0) begin
        ack_cyc[n_ack] = k; ack_who[n_ack] = 0; n_ack++;
        chk("tie_rdata0", RDATA0, (seen0 == 0) ? 32'hC0DE_0008 : 32'hC0DE_000A);
        seen0++;
        if (seen0 == 1) ADDR0 = 32'h28; else REQ0 = 1'b0;
      end else if (ACK1) begin
        ack_cyc[n_ack] = k; ack_who[n_ack] = 1; n_ack++;
        chk("tie_rdata1", RDATA1, (seen1 == 0) ? 32'hC0DE_0009 : 32'hC0DE_000B);
        seen1++;
        if (seen1 == 1) ADDR1 = 32'h2C; else REQ1 = 1'b0;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    chk("tie_count", n_ack, 4);
    for (int i = 0; i < n_ack; i++) begin
      chk("tie_order", ack_who[i], i % 2);
      chk("tie_cycle", ack_cyc[i], 3 * (i + 1));
    end

    do_req(0, 32'h10, 1'b1, 32'hA5A5_5A5A, 4'hF, 3, 32'd0, 1'b0, "wr0");
    do_req(0, 32'h10, 1'b0, 32'd0, 4'hF, 3, 32'hA5A5_5A5A, 1'b0, "rd0");

    wait_cfg = 2;
    do_req(1, 32'h24, 1'b0, 32'd0, 4'h0, 5, 32'hC0DE_0009, 1'b0, "wait1");
    wait_cfg = 0;

    slverr_cfg = 1'b1;
    do_req(1, 32'h30, 1'b1, 32'h1234_5678, 4'h3, 3, 32'd0, 1'b1, "slverr1");
    slverr_cfg = 1'b0;

    // Reset during an ACCESS stall drops the transfer without an ACK.
    @(negedge PCLK);
    ADDR0 = 32'h10; WRITE0 = 1'b0; REQ0 = 1'b1; stuck_low = 1'b1;
    repeat (4) @(negedge PCLK);
    chk("rst_mid_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
    PRESETn = 1'b0; REQ0 = 1'b0;
    #1;
    chk("rst_mid_psel", {30'd0, PSEL, PENABLE}, 32'd0);
    chk("rst_mid_ack", {30'd0, ACK1, ACK0}, 32'd0);
    chk("rst_mid_rdata0", RDATA0, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1; stuck_low = 1'b0;
    ack_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      ack_seen = ack_seen | ACK0 | ACK1 | PSEL;
    end
    chk("rst_mid_quiet", {31'd0, ack_seen}, 32'd0);
    do_req(0, 32'h10, 1'b0, 32'd0, 4'h0, 3, 32'hA5A5_5A5A, 1'b0, "after_rst");

`ifdef APB_ARB_TIMEOUT_EN
    // P_TIMEOUT=4: counter 0..4 over stalled ACCESS cycles, abort on the cycle it reads 4.
    stuck_low = 1'b1;
    do_req(0, 32'h20, 1'b0, 32'd0, 4'h0, 7, 32'd0, 1'b1, "timeout0");
    stuck_low = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mem_arbiter.md
# apb_mem_arbiter

Two-requester APB master that shares one APB3/APB4 slave, typically the team's APB memory model, between two simple request/acknowledge clients. It arbitrates round-robin, sequences the APB SETUP and ACCESS phases, and honours PREADY wait states. It returns read data and PSLVERR to the granted requester. An optional watchdog aborts transfers stalled on PREADY.

## Interface
- ADDRWIDTH, 32, width of PADDR and ADDR0/ADDR1
- P_TIMEOUT, 255, ACCESS-phase wait cycles (PREADY low) tolerated before abort; legal 1..255; used only with the watchdog
- PCLK  in  1  APB clock
- PRESETn  in  1  reset, asynchronous, active-low
- REQ0 / REQ1  in  1  transfer request; held with its command fields until the matching ACK
- ADDR0 / ADDR1  in  ADDRWIDTH  byte address
- WRITE0 / WRITE1  in  1  1 = write, 0 = read
- WDATA0 / WDATA1  in  32  write data
- STRB0 / STRB1  in  4  write byte strobes
- ACK0 / ACK1  out  1  one-cycle completion pulse
- RDATA0 / RDATA1  out  32  read data; valid with ACK, then held
- ERR0 / ERR1  out  1  error flag, pulsed with ACK
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDRWIDTH  APB address
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB strobes; forced to 0 on reads
- PPROT  out  3  constant 3'b000
- PREADY, PSLVERR  in  1  slave response
- PRDATA  in  32  slave read data

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS. All outputs are registered.
- IDLE:
  - A requester is eligible when its REQn is high and its ACKn is not currently high. This masks the requester's stale REQ in its ACK cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On a grant, the command (PADDR, PWRITE, PWDATA, PSTRB) is latched, PSEL is set to 1, and the FSM moves to SETUP.
- SETUP: PENABLE is set to 1, then the FSM moves to ACCESS. The command stays stable.
- ACCESS with PREADY=1 sampled:
  - PSEL and PENABLE return to 0.
  - ACKn is set to 1 and ERRn to PSLVERR.
  - On a read, RDATAn takes PRDATA. On a write, RDATAn is unchanged.
  - The grant pointer updates and the FSM returns to IDLE.
- ACCESS with PREADY=0: the FSM holds and all APB outputs remain stable.
- ACK and ERR are high for exactly one cycle.
- The other requester may be granted in the same IDLE cycle as an ACK, giving back-to-back transfers.
- Requester command changes while REQ is pending have no effect after the grant.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, ACK0/1, ERR0/1 and RDATA0/1 are all 0. The FSM is in IDLE and the pointer is 1.
- Latency with PREADY=1, REQ sampled at edge N:
  - PSEL is high in cycle N+1.
  - PENABLE is high in cycle N+2.
  - ACK is high in cycle N+3.
- Each PREADY-low ACCESS cycle adds one cycle.
- Steady-state throughput is 1 transfer per 3 cycles.
- Asserting PRESETn low mid-transfer takes all outputs to their reset values immediately. The transfer is dropped with no ACK, and the requester must re-request.
- Both REQs rising in the same cycle as an ACK to requester 0 results in requester 1 being granted.

## Configuration
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter equals P_TIMEOUT and PREADY=0, the transfer aborts. PSEL and PENABLE go to 0, ACKn=1, ERRn=1, and RDATAn is set to 0 on a read. The FSM returns to IDLE.
  - If PREADY=1 arrives in that same cycle, normal completion wins.
- Undefined: no counter is built and the FSM waits on PREADY indefinitely.

## Test plan
- Single write then read, PREADY=1: REQ0 writes 0xA5A5_5A5A to 0x10 with STRB=4'hF, then reads 0x10. Required: each ACK0 arrives 3 cycles after REQ, RDATA0=0xA5A5_5A5A, ERR0=0.
- Tie arbitration: REQ0 and REQ1 high together from reset, each reading a distinct preloaded word. Required:
  - Order is 0, 1, 0, 1.
  - ACKs are 3 cycles apart.
  - Each RDATA matches its own address.
- Wait states: slave holds PREADY low 2 cycles in ACCESS. Required: PSEL, PENABLE and PADDR are stable throughout, and ACK arrives 5 cycles after REQ.
- Slave error: PSLVERR=1 with PREADY=1 on a write. Required: ERR1=1 for exactly one cycle, coincident with ACK1.
- Reset mid-ACCESS: PRESETn pulsed low during a PREADY stall. Required: PSEL=0 and no ACK. After release, a fresh REQ0 completes normally.
- Timeout (APB_ARB_TIMEOUT_EN, P_TIMEOUT=4): PREADY is stuck low. Required: ACK0=1 and ERR0=1 after 4 stalled ACCESS cycles, RDATA0=0, and PSEL drops in the same cycle.
